// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in/serial-out transmitter.
// Optional macro PISO_PARITY_EN appends an even-parity bit to every frame.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

`ifdef PISO_PARITY_EN
    localparam int PISO_PARITY_BITS = 1;
`else
    localparam int PISO_PARITY_BITS = 0;
`endif

    // Sized for WIDTH+1 so the parity-extended frame always fits.
    function automatic int piso_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter shared by the serial transmitter and receiver.
// Supports load-to-zero, increment, and terminal-count flags for now and next cycle.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int CNT_W    = 4,
    parameter int TERMINAL = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_zero,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc,
    output logic             tc_next
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(TERMINAL);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_zero) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign tc      = (cnt_q == TERM);
    assign tc_next = (cnt_d == TERM);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: valid/ready word input, one bit per clock out.
// Build with PISO_PARITY_EN defined to append an even-parity bit after the data bits.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int FRAME = WIDTH + PISO_PARITY_BITS;
    localparam int CNT_W = piso_cnt_width(WIDTH);

    piso_state_e      state_q;
    piso_state_e      state_d;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic             ser_out_q;
    logic             ser_out_d;
    logic             ser_valid_q;
    logic             ser_valid_d;
    logic             ser_last_q;
    logic             ser_last_d;

    logic             accept;
    logic             cnt_load;
    logic             cnt_inc;
    logic [CNT_W-1:0] cnt;
    logic             cnt_tc;
    logic             cnt_tc_next;
    logic             next_bit;
    logic             tail_bit;

`ifdef PISO_PARITY_EN
    logic parity_q;
    logic parity_d;

    assign tail_bit = parity_q;
`else
    assign tail_bit = 1'b0;
`endif

    piso_bit_counter #(
        .CNT_W    (CNT_W),
        .TERMINAL (FRAME - 1)
    ) u_bit_counter (
        .clock     (clock),
        .reset     (reset),
        .load_zero (cnt_load),
        .inc       (cnt_inc),
        .cnt       (cnt),
        .tc        (cnt_tc),
        .tc_next   (cnt_tc_next)
    );

    // Ready in IDLE, or in the final frame bit so a new word can follow with no gap.
    assign load_ready = !reset && ((state_q == IDLE) || ((state_q == SHIFT) && cnt_tc));
    assign accept     = load_valid && load_ready;

    always_comb begin
        next_bit = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
        if ((PISO_PARITY_BITS != 0) && (cnt == CNT_W'(WIDTH - 1))) begin
            next_bit = tail_bit;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        cnt_load    = 1'b0;
        cnt_inc     = 1'b0;
`ifdef PISO_PARITY_EN
        parity_d    = parity_q;
`endif

        // The first bit goes straight to the output register; the rest stay queued.
        if (accept) begin
            state_d     = SHIFT;
            cnt_load    = 1'b1;
            ser_valid_d = 1'b1;
            ser_out_d   = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
            shift_d     = MSB_FIRST ? (load_data << 1) : (load_data >> 1);
`ifdef PISO_PARITY_EN
            parity_d    = ^load_data;
`endif
        end else if (state_q == SHIFT) begin
            if (!cnt_tc) begin
                cnt_inc     = 1'b1;
                ser_valid_d = 1'b1;
                ser_out_d   = next_bit;
                shift_d     = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
            end else begin
                state_d  = IDLE;
                cnt_load = 1'b1;
                shift_d  = '0;
`ifdef PISO_PARITY_EN
                parity_d = 1'b0;
`endif
            end
        end
    end

    assign ser_last_d = ser_valid_d && cnt_tc_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            ser_last_q  <= ser_last_d;
`ifdef PISO_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign ser_last  = ser_last_q;
    assign busy      = ser_valid_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer; runs MSB-first and LSB-first instances side by side.
// Honours PISO_PARITY_EN: frames grow to 9 bits and the hand-written parity bits are checked.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       load_valid;
    logic [7:0] load_data;

    logic m_ready, m_out, m_valid, m_last, m_busy;
    logic l_ready, l_out, l_valid, l_last, l_busy;

    int pass_count  = 0;
    int total_count = 0;

    always #5 clock = ~clock;

    piso_serializer #(
        .WIDTH     (8),
        .MSB_FIRST (1'b1)
    ) dut_msb (
        .clock      (clock),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (m_ready),
        .load_data  (load_data),
        .ser_out    (m_out),
        .ser_valid  (m_valid),
        .ser_last   (m_last),
        .busy       (m_busy)
    );

    piso_serializer #(
        .WIDTH     (8),
        .MSB_FIRST (1'b0)
    ) dut_lsb (
        .clock      (clock),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (l_ready),
        .load_data  (load_data),
        .ser_out    (l_out),
        .ser_valid  (l_valid),
        .ser_last   (l_last),
        .busy       (l_busy)
    );

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] data);
        load_valid = valid;
        load_data  = data;
    endtask

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        total_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".m_valid"}, m_valid, 1'b0);
        checkOutput({tag, ".m_out"},   m_out,   1'b0);
        checkOutput({tag, ".m_last"},  m_last,  1'b0);
        checkOutput({tag, ".m_busy"},  m_busy,  1'b0);
        checkOutput({tag, ".m_ready"}, m_ready, 1'b1);
        checkOutput({tag, ".l_valid"}, l_valid, 1'b0);
        checkOutput({tag, ".l_out"},   l_out,   1'b0);
        checkOutput({tag, ".l_ready"}, l_ready, 1'b1);
    endtask

    // Offers a word in the current cycle and steps to the first frame bit.
    task automatic startFrame(input string tag, input logic [7:0] word);
        applyStimulus(1'b1, word);
        checkOutput({tag, ".accept.m_ready"}, m_ready, 1'b1);
        checkOutput({tag, ".accept.l_ready"}, l_ready, 1'b1);
        nextCycle();
    endtask

    // seq_* hold the bits in send order: data bits in [8:1], parity bit in [0].
    task automatic playFrame(input string tag, input logic [8:0] seq_m, input logic [8:0] seq_l,
                             input logic offer_all, input logic offer_last, input logic [7:0] offer_word);
        for (int i = 0; i < FRAME; i++) begin
            logic is_last;
            string t;
            is_last = (i == FRAME - 1);
            t = $sformatf("%s[%0d]", tag, i);
            applyStimulus(offer_all || (offer_last && is_last), offer_word);
            checkOutput({t, ".m_valid"}, m_valid, 1'b1);
            checkOutput({t, ".m_busy"},  m_busy,  1'b1);
            checkOutput({t, ".m_out"},   m_out,   seq_m[8-i]);
            checkOutput({t, ".m_last"},  m_last,  is_last);
            checkOutput({t, ".m_ready"}, m_ready, is_last);
            checkOutput({t, ".l_valid"}, l_valid, 1'b1);
            checkOutput({t, ".l_out"},   l_out,   seq_l[8-i]);
            checkOutput({t, ".l_last"},  l_last,  is_last);
            checkOutput({t, ".l_ready"}, l_ready, is_last);
            nextCycle();
        end
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 8'h00);
        nextCycle();
        nextCycle();
        checkOutput("rst.m_ready", m_ready, 1'b0);
        checkOutput("rst.l_ready", l_ready, 1'b0);
        checkOutput("rst.m_valid", m_valid, 1'b0);
        checkOutput("rst.m_out",   m_out,   1'b0);
        checkOutput("rst.m_last",  m_last,  1'b0);
        checkOutput("rst.m_busy",  m_busy,  1'b0);
        checkOutput("rst.l_valid", l_valid, 1'b0);

        reset = 1'b0;
        #1;
        checkIdle("post_rst");

        // Single 0xA5 frame, both bit orders (palindromic), then idle.
        startFrame("a5", 8'hA5);
        playFrame("a5", {8'b1010_0101, 1'b0}, {8'b1010_0101, 1'b0}, 1'b0, 1'b0, 8'h00);
        checkIdle("a5_end");

        // Back-to-back: 0x3C accepted in the ser_last cycle of 0xA5.
        startFrame("b2b", 8'hA5);
        playFrame("b2b_a5", {8'b1010_0101, 1'b0}, {8'b1010_0101, 1'b0}, 1'b0, 1'b1, 8'h3C);
        playFrame("b2b_3c", {8'b0011_1100, 1'b0}, {8'b0011_1100, 1'b0}, 1'b0, 1'b0, 8'h00);
        checkIdle("b2b_end");

        // 0x01 separates MSB-first from LSB-first.
        startFrame("x01", 8'h01);
        playFrame("x01", {8'b0000_0001, 1'b1}, {8'b1000_0000, 1'b1}, 1'b0, 1'b0, 8'h00);
        checkIdle("x01_end");

        // 0xFF held valid through the frame is only taken in the last bit cycle.
        startFrame("hold", 8'hA5);
        playFrame("hold_a5", {8'b1010_0101, 1'b0}, {8'b1010_0101, 1'b0}, 1'b1, 1'b0, 8'hFF);
        playFrame("hold_ff", {8'b1111_1111, 1'b0}, {8'b1111_1111, 1'b0}, 1'b0, 1'b0, 8'h00);
        checkIdle("hold_end");

        // Reset in the third bit cycle aborts the frame.
        startFrame("mid", 8'hA5);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 8'h00);
            checkOutput($sformatf("mid[%0d].m_valid", i), m_valid, 1'b1);
            checkOutput($sformatf("mid[%0d].m_out", i), m_out, (i == 0) ? 1'b1 : 1'b0);
            nextCycle();
        end
        reset = 1'b1;
        #1;
        checkOutput("mid_rst.m_ready", m_ready, 1'b0);
        checkOutput("mid_rst.l_ready", l_ready, 1'b0);
        checkOutput("mid_rst.m_out",   m_out,   1'b1);
        nextCycle();
        checkOutput("mid_abort.m_valid", m_valid, 1'b0);
        checkOutput("mid_abort.l_valid", l_valid, 1'b0);
        reset = 1'b0;
        #1;
        checkIdle("mid_after");
        startFrame("mid_3c", 8'h3C);
        playFrame("mid_3c", {8'b0011_1100, 1'b0}, {8'b0011_1100, 1'b0}, 1'b0, 1'b0, 8'h00);
        checkIdle("mid_end");

        // 0x07 has odd weight, so its parity bit is 1.
        startFrame("x07", 8'h07);
        playFrame("x07", {8'b0000_0111, 1'b1}, {8'b1110_0000, 1'b1}, 1'b0, 1'b0, 8'h00);
        checkIdle("x07_end");

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
